// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: digit codes, glyph patterns, slot states.
package seg_pkg;

  localparam logic [3:0] SEG_CODE_SEP   = 4'd10;
  localparam logic [3:0] SEG_CODE_BLANK = 4'd11;

  // Patterns are packed {g,f,e,d,c,b,a}, segment a in bit 0.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_bits_t;

  typedef logic [6:0] seg_pat_t;

  localparam seg_pat_t PAT_0   = 7'h3F;
  localparam seg_pat_t PAT_1   = 7'h06;
  localparam seg_pat_t PAT_2   = 7'h5B;
  localparam seg_pat_t PAT_3   = 7'h4F;
  localparam seg_pat_t PAT_4   = 7'h66;
  localparam seg_pat_t PAT_5   = 7'h6D;
  localparam seg_pat_t PAT_6   = 7'h7D;
  localparam seg_pat_t PAT_7   = 7'h07;
  localparam seg_pat_t PAT_8   = 7'h7F;
  localparam seg_pat_t PAT_9   = 7'h6F;
  localparam seg_pat_t PAT_SEP = 7'h40;
  localparam seg_pat_t PAT_OFF = 7'h00;

  typedef enum logic {
    ST_DEAD,
    ST_SHOW
  } slot_st_t;

endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-high seven-segment glyph.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output seg_pat_t   pat
);

  always_comb begin
    pat = PAT_OFF;
    case (code)
      4'd0:         pat = PAT_0;
      4'd1:         pat = PAT_1;
      4'd2:         pat = PAT_2;
      4'd3:         pat = PAT_3;
      4'd4:         pat = PAT_4;
      4'd5:         pat = PAT_5;
      4'd6:         pat = PAT_6;
      4'd7:         pat = PAT_7;
      4'd8:         pat = PAT_8;
      4'd9:         pat = PAT_9;
      SEG_CODE_SEP: pat = PAT_SEP;
      default:      pat = PAT_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with dead time,
// per-digit blink/dot and registered board-pin outputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SLOT_CYCLES    = 12500,
  parameter int DEAD_CYCLES    = 16,
  parameter int BLINK_CYCLES   = 25_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] led0,
  input  logic [3:0] led1,
  input  logic [3:0] led2,
  input  logic [3:0] led3,
  input  logic [3:0] led4,
  input  logic [3:0] led5,
  input  logic [3:0] led6,
  input  logic [3:0] led7,
  input  logic [7:0] blink_mask,
  input  logic [7:0] dot_mask,
  input  logic       blank,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam slot_st_t ST_RST = (DEAD_CYCLES > 0) ? ST_DEAD : ST_SHOW;

  logic [SW-1:0] slot_cnt, slot_nxt;
  logic [2:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  slot_st_t      st, st_nxt;

  logic [3:0] cap_code;
  logic       cap_dot, cap_blink;
  logic [3:0] leds [8];
  logic [3:0] code_eff;
  logic       dot_eff, blink_eff, cap_now, slot_wrap, dark;
  seg_pat_t   pat;
  logic [7:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  assign leds = '{led0, led1, led2, led3, led4, led5, led6, led7};

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign cap_now   = (slot_cnt == '0);

  // The capture cycle uses the live inputs so the slot starts on fresh data.
  assign code_eff  = cap_now ? leds[digit_idx] : cap_code;
  assign dot_eff   = cap_now ? dot_mask[digit_idx] : cap_dot;
  assign blink_eff = cap_now ? blink_mask[digit_idx] : cap_blink;
  assign dark      = blank | (blink_eff & blink_phase);

  seg7_decode u_dec (
    .code (code_eff),
    .pat  (pat)
  );

  always_ff @(posedge clk) begin
    if (rst) st <= ST_RST;
    else     st <= st_nxt;
  end

  always_comb begin
    slot_nxt = slot_wrap ? '0 : slot_cnt + 1'b1;
    st_nxt   = (int'(slot_nxt) < DEAD_CYCLES) ? ST_DEAD : ST_SHOW;
    an_d     = '0;
    seg_d    = '0;
    dp_d     = 1'b0;
    unique case (st)
      ST_DEAD: ;
      ST_SHOW: begin
        an_d = 8'd1 << digit_idx;
        if (!dark) begin
          seg_d = pat;
          dp_d  = dot_eff;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      cap_code    <= SEG_CODE_BLANK;
      cap_dot     <= 1'b0;
      cap_blink   <= 1'b0;
      an          <= {8{AN_ACTIVE_LOW}};
      seg         <= {7{SEG_ACTIVE_LOW}};
      dp          <= SEG_ACTIVE_LOW;
    end else begin
      slot_cnt <= slot_nxt;
      if (slot_wrap) digit_idx <= digit_idx + 3'd1;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      if (cap_now) begin
        cap_code  <= code_eff;
        cap_dot   <= dot_eff;
        cap_blink <= blink_eff;
      end
      an  <= an_d ^ {8{AN_ACTIVE_LOW}};
      seg <= seg_d ^ {7{SEG_ACTIVE_LOW}};
      dp  <= dp_d ^ SEG_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench: directed scenarios plus random inputs against
// a cycle-indexed reference of the scan schedule.
module tb_seg_scan_driver;

  localparam int S = 8;
  localparam int D = 2;
  localparam int B = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ledv [8];
  logic [7:0] blink_mask = '0;
  logic [7:0] dot_mask = '0;
  logic       blank = 1'b0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int errors = 0;
  int checks = 0;

  int n = 0;
  logic [3:0] m_code = 4'd11;
  logic       m_dot = 1'b0;
  logic       m_blink = 1'b0;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                             7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h00,
                             7'h00, 7'h00, 7'h00, 7'h00};

  seg_scan_driver #(
    .SLOT_CYCLES    (S),
    .DEAD_CYCLES    (D),
    .BLINK_CYCLES   (B),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .led0       (ledv[0]),
    .led1       (ledv[1]),
    .led2       (ledv[2]),
    .led3       (ledv[3]),
    .led4       (ledv[4]),
    .led5       (ledv[5]),
    .led6       (ledv[6]),
    .led7       (ledv[7]),
    .blink_mask (blink_mask),
    .dot_mask   (dot_mask),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  // Expected pins for the cycle after cycle n (one register stage).
  task automatic model();
    int slot, dig, ph;
    logic dark;
    slot = n % S;
    dig  = (n / S) % 8;
    ph   = (n / B) % 2;
    if (slot == 0) begin
      m_code  = ledv[dig];
      m_dot   = dot_mask[dig];
      m_blink = blink_mask[dig];
    end
    if (slot < D) begin
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      dark  = blank || (m_blink && ph == 1);
      e_an  = ~(8'd1 << dig);
      e_seg = dark ? 7'h7F : ~glyph[m_code];
      e_dp  = dark ? 1'b1 : ~m_dot;
    end
  endtask

  task automatic tick(input bit r);
    rst = r;
    if (r) begin
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      n = 0;
    end else begin
      model();
      n++;
    end
    @(negedge clk);
    checks++;
    assert (an === e_an) else begin
      errors++;
      $error("FAIL an n=%0d got %h expected %h", n, an, e_an);
    end
    checks++;
    assert (seg === e_seg) else begin
      errors++;
      $error("FAIL seg n=%0d got %h expected %h", n, seg, e_seg);
    end
    checks++;
    assert (dp === e_dp) else begin
      errors++;
      $error("FAIL dp n=%0d got %b expected %b", n, dp, e_dp);
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0);
  endtask

  // Advance until the coming cycle is digit d at slot position s.
  task automatic run_to(input int d, input int s);
    for (int i = 0; i < 4 * S * 8; i++) begin
      if ((n % S) == s && ((n / S) % 8) == d) break;
      tick(1'b0);
    end
    checks++;
    assert ((n % S) == s && ((n / S) % 8) == d) else begin
      errors++;
      $error("FAIL run_to got n=%0d expected digit %0d slot %0d", n, d, s);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) ledv[k] = 4'(k);
    dot_mask = 8'h01;
    @(negedge clk);
    repeat (3) tick(1'b1);

    run(S * 8 * 2);

    dot_mask = 8'h80;
    ledv[3] = 4'd10;
    run(S * 8);
    ledv[3] = 4'd11;
    run(S * 8);

    dot_mask = 8'h00;
    blink_mask = 8'h04;
    ledv[2] = 4'd8;
    run(B * 4);
    blink_mask = 8'h00;

    ledv[1] = 4'd5;
    run_to(1, 4);
    ledv[1] = 4'd9;
    run(S * 8 + 4);

    run_to(3, 5);
    blank = 1'b1;
    run(20);
    blank = 1'b0;
    run(10);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 8; k++) ledv[k] = 4'($urandom_range(0, 15));
        blink_mask = 8'($urandom);
        dot_mask   = 8'($urandom);
      end
      blank = ($urandom_range(0, 9) == 0);
      tick(1'b0);
    end
    blank = 1'b0;
    blink_mask = 8'hFF;

    run_to(5, 4);
    tick(1'b1);
    run(S * 8 * 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
